// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for an iterative AES datapath; issues load, key-schedule
// and round enables for NR rounds of ROUND_LAT cycles, then holds the result until accepted.
module aes_round_ctrl #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_out_ready,
    output logic       o_in_ready,
    output logic       o_ld_en,
    output logic       o_ks_en,
    output logic       o_round_en,
    output logic       o_final_round,
    output logic [3:0] o_round_idx,
    output logic       o_out_valid,
    output logic       o_busy
);
    typedef enum logic [1:0] {IDLE, LOAD, ROUND, HOLD} state_t;
    state_t     r_state;
    logic [3:0] r_idx;
    logic [3:0] r_lat;
    logic       w_last;
    logic       w_final;
    assign w_last  = (r_state == ROUND) && (r_lat == 4'(ROUND_LAT - 1));
    assign w_final = (r_state == ROUND) && (r_idx == 4'(NR));
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= 4'd0;
            r_lat   <= 4'd0;
        end else if (i_abort) begin
            r_state <= IDLE;
            r_idx   <= 4'd0;
            r_lat   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: if (i_start) r_state <= LOAD;
                LOAD: begin
                    r_state <= ROUND;
                    r_idx   <= 4'd1;
                    r_lat   <= 4'd0;
                end
                ROUND: begin
                    if (!w_last) r_lat <= r_lat + 4'd1;
                    else if (w_final) r_state <= HOLD;
                    else begin
                        r_idx <= r_idx + 4'd1;
                        r_lat <= 4'd0;
                    end
                end
                HOLD: if (i_out_ready) begin
                    r_state <= IDLE;
                    r_idx   <= 4'd0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    // Enables are gated by abort so a cancelled cycle never touches the datapath.
    assign o_ld_en       = (r_state == LOAD) && !i_abort;
    assign o_round_en    = w_last && !i_abort;
    assign o_ks_en       = o_ld_en || o_round_en;
    assign o_in_ready    = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_out_valid   = (r_state == HOLD);
    assign o_final_round = w_final;
    assign o_round_idx   = r_idx;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for two sequencer configs (NR=10/LAT=1, NR=14/LAT=3).
module tb_aes_round_ctrl;
    typedef struct {int lat; int nre; int nks; int nfr;} exp_t;

    logic       clk;
    logic       rst_n;
    logic       start[2];
    logic       abort[2];
    logic       ordy[2];
    logic       ir[2], ld[2], ks[2], re[2], fr[2], ov[2], bz[2];
    logic [3:0] idx[2];

    int   errs = 0;
    int   checks = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit   active[2];
    bit   pov[2];
    int   cyc_n[2], nre[2], nks[2], nfr[2];

    aes_round_ctrl u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
        .i_out_ready(ordy[0]), .o_in_ready(ir[0]), .o_ld_en(ld[0]), .o_ks_en(ks[0]),
        .o_round_en(re[0]), .o_final_round(fr[0]), .o_round_idx(idx[0]),
        .o_out_valid(ov[0]), .o_busy(bz[0])
    );

    aes_round_ctrl #(.NR(14), .ROUND_LAT(3)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
        .i_out_ready(ordy[1]), .o_in_ready(ir[1]), .o_ld_en(ld[1]), .o_ks_en(ks[1]),
        .o_round_en(re[1]), .o_final_round(fr[1]), .o_round_idx(idx[1]),
        .o_out_valid(ov[1]), .o_busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, int a, int e);
        checks++;
        if (a != e) begin
            errs++;
            $display("FAIL %s act=%0d exp=%0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(int m, int max);
        int n = 0;
        while (!ov[m] && n < max) begin
            tick(1);
            n++;
        end
        chk("out_valid_reached", int'(ov[m]), 1);
    endtask

    task automatic wait_idx(int m, int v, int max);
        int n = 0;
        while (int'(idx[m]) != v && n < max) begin
            tick(1);
            n++;
        end
        chk("round_idx_reached", int'(idx[m]), v);
    endtask

    // Monitor: tracks each accepted block and scores it when out_valid rises.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                active[m] = 0;
                pov[m]    = 0;
            end else begin
                chk("in_ready_vs_busy", int'(ir[m]), int'(!bz[m]));
                if (ld[m] || re[m] || ks[m]) begin
                    chk("ks_is_ld_or_round", int'(ks[m]), int'(ld[m] | re[m]));
                    chk("ld_round_exclusive", int'(ld[m] & re[m]), 0);
                end
                if (abort[m]) chk("abort_no_ks", int'(ks[m]), 0);
                if (active[m]) begin
                    if (abort[m]) active[m] = 0;
                    else begin
                        cyc_n[m]++;
                        if (re[m]) begin
                            nre[m]++;
                            chk("round_en_idx", int'(idx[m]), nre[m]);
                        end
                        if (ks[m]) nks[m]++;
                        if (fr[m]) begin
                            nfr[m]++;
                            chk("final_round_idx", int'(idx[m]), (m == 0) ? 10 : 14);
                        end
                        if (ov[m] && !pov[m]) begin
                            exp_t e;
                            if ((m == 0 ? q0.size() : q1.size()) == 0) begin
                                chk("expected_entry_present", 0, 1);
                            end else begin
                                if (m == 0) e = q0.pop_front();
                                else e = q1.pop_front();
                                chk("latency", cyc_n[m], e.lat);
                                chk("round_en_count", nre[m], e.nre);
                                chk("ks_en_count", nks[m], e.nks);
                                chk("final_round_cycles", nfr[m], e.nfr);
                            end
                            active[m] = 0;
                        end
                    end
                end else if (ov[m] && !pov[m]) begin
                    chk("unexpected_out_valid", 1, 0);
                end
                if (ir[m] && start[m] && !abort[m]) begin
                    active[m] = 1;
                    cyc_n[m]  = 0;
                    nre[m]    = 0;
                    nks[m]    = 0;
                    nfr[m]    = 0;
                end
                pov[m] = ov[m];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=1 exp=0");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            start[m] = 0;
            abort[m] = 0;
            ordy[m]  = 0;
        end
        tick(2);
        chk("rst_in_ready", int'(ir[0]), 1);
        chk("rst_busy", int'(bz[0]), 0);
        chk("rst_ld_en", int'(ld[0]), 0);
        chk("rst_ks_en", int'(ks[0]), 0);
        chk("rst_round_en", int'(re[0]), 0);
        chk("rst_final_round", int'(fr[0]), 0);
        chk("rst_round_idx", int'(idx[0]), 0);
        chk("rst_out_valid", int'(ov[0]), 0);
        chk("rst_u1_in_ready", int'(ir[1]), 1);
        rst_n = 1'b1;
        tick(1);

        // Basic block, then a long stall in HOLD
        start[0] = 1;
        q0.push_back(exp_t'{12, 10, 11, 1});
        tick(1);
        start[0] = 0;
        chk("load_ld_en", int'(ld[0]), 1);
        chk("load_round_idx", int'(idx[0]), 0);
        wait_ov(0, 30);
        chk("hold_round_idx", int'(idx[0]), 10);
        for (int i = 0; i < 20; i++) begin
            chk("hold_out_valid", int'(ov[0]), 1);
            chk("hold_no_ks", int'(ks[0]), 0);
            tick(1);
        end
        ordy[0] = 1;
        tick(1);
        ordy[0] = 0;
        chk("after_accept_in_ready", int'(ir[0]), 1);
        chk("after_accept_idx", int'(idx[0]), 0);
        chk("after_accept_out_valid", int'(ov[0]), 0);

        // NR=14, ROUND_LAT=3
        start[1] = 1;
        q1.push_back(exp_t'{44, 14, 15, 3});
        tick(1);
        start[1] = 0;
        wait_ov(1, 60);
        ordy[1] = 1;
        tick(1);
        ordy[1] = 0;
        chk("u1_after_accept_in_ready", int'(ir[1]), 1);

        // Start while busy is ignored; held start gives a back-to-back block
        start[0] = 1;
        q0.push_back(exp_t'{12, 10, 11, 1});
        tick(1);
        start[0] = 0;
        wait_idx(0, 5, 20);
        start[0] = 1;
        tick(1);
        start[0] = 0;
        wait_ov(0, 30);
        q0.push_back(exp_t'{12, 10, 11, 1});
        start[0] = 1;
        ordy[0]  = 1;
        tick(1);
        ordy[0] = 0;
        chk("b2b_idle_in_ready", int'(ir[0]), 1);
        tick(1);
        start[0] = 0;
        chk("b2b_load_ld_en", int'(ld[0]), 1);
        wait_ov(0, 30);
        ordy[0] = 1;
        tick(1);
        ordy[0] = 0;

        // Abort mid-round, then abort+start together in IDLE
        start[0] = 1;
        tick(1);
        start[0] = 0;
        wait_idx(0, 4, 20);
        abort[0] = 1;
        #1;
        chk("abort_round_en", int'(re[0]), 0);
        chk("abort_ks_en", int'(ks[0]), 0);
        tick(1);
        abort[0] = 0;
        chk("abort_in_ready", int'(ir[0]), 1);
        chk("abort_round_idx", int'(idx[0]), 0);
        abort[0] = 1;
        start[0] = 1;
        tick(1);
        abort[0] = 0;
        start[0] = 0;
        chk("abort_start_stays_idle", int'(ir[0]), 1);
        chk("abort_start_no_load", int'(ld[0]), 0);
        tick(1);
        chk("abort_start_still_idle", int'(bz[0]), 0);

        // Asynchronous reset between edges mid-round
        start[0] = 1;
        tick(1);
        start[0] = 0;
        wait_idx(0, 6, 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_in_ready", int'(ir[0]), 1);
        chk("async_rst_idx", int'(idx[0]), 0);
        chk("async_rst_round_en", int'(re[0]), 0);
        chk("async_rst_busy", int'(bz[0]), 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        start[0] = 1;
        q0.push_back(exp_t'{12, 10, 11, 1});
        tick(1);
        start[0] = 0;
        wait_ov(0, 30);
        ordy[0] = 1;
        tick(1);
        ordy[0] = 0;

        tick(3);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
